// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: default sizing, FSM states
// and the saturating-counter midpoint.
package bp_pkg;

    localparam int DEF_IDX_BITS  = 8;
    localparam int DEF_TAG_BITS  = 8;
    localparam int DEF_CTR_BITS  = 2;
    localparam int DEF_STAT_BITS = 16;

    // Weakly-taken value of a counter; one below is weakly-not-taken.
    localparam int DEF_CTR_MID   = 1 << (DEF_CTR_BITS - 1);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        INIT  = 2'd1,
        RUN   = 2'd2
    } bp_state_t;

    function automatic int ctr_mid(input int bits);
        return 1 << (bits - 1);
    endfunction

endpackage

// File: rtl/branch_predictor_sat_ctr.sv
// Saturating up/down counter step: the next value of a prediction counter
// given the resolved branch direction.
module sat_ctr #(
    parameter int CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] cur,
    input  logic                inc,
    output logic [CTR_BITS-1:0] nxt
);

    // Step toward the outcome, sticking at either end.
    always_comb begin
        nxt = cur;
        if (inc) begin
            if (cur != '1) nxt = cur + 1'b1;
        end else begin
            if (cur != '0) nxt = cur - 1'b1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Tagged branch target buffer with per-entry saturating direction counters.
// Table is cleared by a one-entry-per-cycle sweep, optionally preloaded,
// then trained by resolved branches while serving zero-latency lookups.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int IDX_BITS  = DEF_IDX_BITS,
    parameter int TAG_BITS  = DEF_TAG_BITS,
    parameter int CTR_BITS  = DEF_CTR_BITS,
    parameter int STAT_BITS = DEF_STAT_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init_en,
    input  logic [IDX_BITS-1:0]  init_idx,
    input  logic [TAG_BITS-1:0]  init_tag,
    input  logic [31:0]          init_target,
    input  logic [CTR_BITS-1:0]  init_ctr,
    input  logic                 init_done,
    input  logic [31:0]          if_pc,
    output logic                 pred_hit,
    output logic                 pred_taken,
    output logic [31:0]          pred_target,
    input  logic                 upd_valid,
    input  logic [31:0]          upd_pc,
    input  logic                 upd_taken,
    input  logic [31:0]          upd_target,
    input  logic                 upd_pred_taken,
    input  logic [31:0]          upd_pred_target,
    output logic                 ready,
    output logic                 mispredict,
    output logic [31:0]          redirect_pc,
    output logic [STAT_BITS-1:0] stat_branches,
    output logic [STAT_BITS-1:0] stat_miss
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_WEAK_T = CTR_BITS'(ctr_mid(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_WEAK_N = CTR_BITS'(ctr_mid(CTR_BITS) - 1);

    bp_state_t state_q, state_d;
    logic [IDX_BITS-1:0] clr_idx;

    logic [ENTRIES-1:0]  tbl_valid;
    logic [TAG_BITS-1:0] tbl_tag [ENTRIES];
    logic [31:0]         tbl_tgt [ENTRIES];
    logic [CTR_BITS-1:0] tbl_ctr [ENTRIES];

    logic [IDX_BITS-1:0] f_idx, u_idx;
    logic [TAG_BITS-1:0] f_tag, u_tag;
    logic                f_hit, u_hit, upd_acc, misp_cond;
    logic [CTR_BITS-1:0] ctr_nxt;

    assign f_idx = if_pc[IDX_BITS+1:2];
    assign f_tag = if_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign u_idx = upd_pc[IDX_BITS+1:2];
    assign u_tag = upd_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

    assign f_hit     = tbl_valid[f_idx] && (tbl_tag[f_idx] == f_tag);
    assign u_hit     = tbl_valid[u_idx] && (tbl_tag[u_idx] == u_tag);
    assign upd_acc   = ready && upd_valid;
    assign misp_cond = (upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_target != upd_pred_target));

    sat_ctr #(.CTR_BITS(CTR_BITS)) u_sat_ctr (
        .cur (tbl_ctr[u_idx]),
        .inc (upd_taken),
        .nxt (ctr_nxt)
    );

    // FSM state register; reset always restarts from the clear sweep.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= CLEAR;
        else      state_q <= state_d;
    end

    // FSM next state: sweep every index, wait for preload end, then run.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   if (clr_idx == '1) state_d = INIT;
            INIT:    if (init_done)     state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = CLEAR;
        endcase
    end

    // FSM outputs: predictions and training are live only in RUN.
    always_comb begin
        ready = (state_q == RUN);
    end

    // Sweep pointer, restarted at index 0 by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 clr_idx <= '0;
        else if (state_q == CLEAR) clr_idx <= clr_idx + 1'b1;
    end

    // Entry valid bits: reset empties the table immediately, the sweep re-clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tbl_valid <= '0;
        end else begin
            case (state_q)
                CLEAR: tbl_valid[clr_idx] <= 1'b0;
                INIT:  if (init_en) tbl_valid[init_idx] <= 1'b1;
                RUN:   if (upd_valid && !u_hit && upd_taken) tbl_valid[u_idx] <= 1'b1;
                default: ;
            endcase
        end
    end

    // Entry payload (tag/target/counter); plain registers, no reset needed
    // because nothing reads them until the sweep and preload have run.
    always_ff @(posedge clk) begin
        case (state_q)
            CLEAR: tbl_ctr[clr_idx] <= CTR_WEAK_N;
            INIT: begin
                if (init_en) begin
                    tbl_tag[init_idx] <= init_tag;
                    tbl_tgt[init_idx] <= init_target;
                    tbl_ctr[init_idx] <= init_ctr;
                end
            end
            RUN: begin
                if (upd_valid) begin
                    if (u_hit) begin
                        tbl_ctr[u_idx] <= ctr_nxt;
                        if (upd_taken) tbl_tgt[u_idx] <= upd_target;
                    end else if (upd_taken) begin
                        tbl_tag[u_idx] <= u_tag;
                        tbl_tgt[u_idx] <= upd_target;
                        tbl_ctr[u_idx] <= CTR_WEAK_T;
                    end
                end
            end
            default: ;
        endcase
    end

    // Zero-latency lookup; falls through to the sequential PC on a miss.
    always_comb begin
        pred_hit    = ready && f_hit;
        pred_taken  = ready && f_hit && tbl_ctr[f_idx][CTR_BITS-1];
        pred_target = pred_hit ? tbl_tgt[f_idx] : if_pc + 32'd4;
    end

    // Resolution outputs and saturating statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mispredict    <= 1'b0;
            redirect_pc   <= '0;
            stat_branches <= '0;
            stat_miss     <= '0;
        end else begin
            mispredict <= upd_acc && misp_cond;
            if (upd_acc) begin
                redirect_pc <= upd_taken ? upd_target : upd_pc + 32'd4;
                if (stat_branches != '1) stat_branches <= stat_branches + 1'b1;
                if (misp_cond && (stat_miss != '1)) stat_miss <= stat_miss + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a driver pushes expected outputs
// from a behavioural table model, a negedge monitor pops and compares.
module tb_branch_predictor;

    localparam int IB = 8, TB = 8, CB = 2, SB = 4;
    localparam int NENT = 256, CMAX = 3, MID = 2, SMAX = 15;

    logic          clk = 1'b0, rst = 1'b0;
    logic          init_en = 0, init_done = 0;
    logic [IB-1:0] init_idx = '0;
    logic [TB-1:0] init_tag = '0;
    logic [31:0]   init_target = '0;
    logic [CB-1:0] init_ctr = '0;
    logic [31:0]   if_pc = '0;
    logic          pred_hit, pred_taken;
    logic [31:0]   pred_target;
    logic          upd_valid = 0, upd_taken = 0, upd_pred_taken = 0;
    logic [31:0]   upd_pc = '0, upd_target = '0, upd_pred_target = '0;
    logic          ready, mispredict;
    logic [31:0]   redirect_pc;
    logic [SB-1:0] stat_branches, stat_miss;

    branch_predictor #(.IDX_BITS(IB), .TAG_BITS(TB), .CTR_BITS(CB), .STAT_BITS(SB)) dut (
        .clk(clk), .rst(rst),
        .init_en(init_en), .init_idx(init_idx), .init_tag(init_tag),
        .init_target(init_target), .init_ctr(init_ctr), .init_done(init_done),
        .if_pc(if_pc), .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .ready(ready), .mispredict(mispredict), .redirect_pc(redirect_pc),
        .stat_branches(stat_branches), .stat_miss(stat_miss)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int          m_mode;               // 0 clearing, 1 preloading, 2 running
    int          m_sweep;
    bit          m_valid [NENT];
    int          m_tag   [NENT];
    logic [31:0] m_tgt   [NENT];
    int          m_ctr   [NENT];
    bit          m_misp;
    logic [31:0] m_redir;
    int          m_sb, m_sm;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) & 32'hFF);
    endfunction
    function automatic int tag_of(input logic [31:0] pc);
        return int'((pc >> 10) & 32'hFF);
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_sweep = 0; m_misp = 0; m_redir = '0; m_sb = 0; m_sm = 0;
    endfunction

    function automatic void mpred(input logic [31:0] pc, output logic h, output logic t,
                                  output logic [31:0] tg);
        int i;
        i = idx_of(pc);
        h = (m_mode == 2) && m_valid[i] && (m_tag[i] == tag_of(pc));
        t = h && (m_ctr[i] >= MID);
        tg = h ? m_tgt[i] : pc + 32'd4;
    endfunction

    // Applies one clock edge to the model using the inputs held during the cycle.
    function automatic void model_edge();
        int  i;
        bit  hit, bad;
        if (!rst) begin model_reset(); return; end
        if (m_mode == 0) begin
            m_valid[m_sweep] = 0; m_ctr[m_sweep] = MID - 1;
            m_sweep++;
            if (m_sweep == NENT) m_mode = 1;
            m_misp = 0;
        end else if (m_mode == 1) begin
            if (init_en) begin
                i = int'(init_idx);
                m_valid[i] = 1; m_tag[i] = int'(init_tag);
                m_tgt[i] = init_target; m_ctr[i] = int'(init_ctr);
            end
            if (init_done) m_mode = 2;
            m_misp = 0;
        end else if (upd_valid) begin
            i   = idx_of(upd_pc);
            hit = m_valid[i] && (m_tag[i] == tag_of(upd_pc));
            bad = (upd_taken != upd_pred_taken) || (upd_taken && upd_target != upd_pred_target);
            m_misp  = bad;
            m_redir = upd_taken ? upd_target : upd_pc + 32'd4;
            if (m_sb < SMAX) m_sb++;
            if (bad && m_sm < SMAX) m_sm++;
            if (hit) begin
                m_ctr[i] = upd_taken ? ((m_ctr[i] < CMAX) ? m_ctr[i] + 1 : CMAX)
                                     : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
                if (upd_taken) m_tgt[i] = upd_target;
            end else if (upd_taken) begin
                m_valid[i] = 1; m_tag[i] = tag_of(upd_pc);
                m_tgt[i] = upd_target; m_ctr[i] = MID;
            end
        end else begin
            m_misp = 0;
        end
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        string       name;
        logic        hit, taken, rdy, misp;
        logic [31:0] tgt, redir;
        int          sb, sm;
    } exp_t;

    exp_t q[$];
    int   vectors = 0, miscompares = 0;

    task automatic push(input string nm);
        exp_t e;
        e.name = nm;
        mpred(if_pc, e.hit, e.taken, e.tgt);
        e.rdy = (m_mode == 2); e.misp = m_misp; e.redir = m_redir;
        e.sb = m_sb; e.sm = m_sm;
        q.push_back(e);
    endtask

    // One cycle: expectation for this cycle, then the edge.
    task automatic cycle(input string nm);
        push(nm);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Monitor: compare every presented output set against the queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            if (pred_hit !== e.hit || pred_taken !== e.taken || pred_target !== e.tgt ||
                ready !== e.rdy || mispredict !== e.misp || redirect_pc !== e.redir ||
                int'(stat_branches) != e.sb || int'(stat_miss) != e.sm) begin
                miscompares++;
                $display("FAIL %s: got hit=%0b tk=%0b tgt=%h rdy=%0b misp=%0b redir=%h sb=%0d sm=%0d, want hit=%0b tk=%0b tgt=%h rdy=%0b misp=%0b redir=%h sb=%0d sm=%0d",
                    e.name, pred_hit, pred_taken, pred_target, ready, mispredict, redirect_pc,
                    stat_branches, stat_miss, e.hit, e.taken, e.tgt, e.rdy, e.misp, e.redir, e.sb, e.sm);
            end
        end
    end

    // Drive an update whose "fetch prediction" is what the model predicts now.
    task automatic upd_model(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        logic h;
        upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
        mpred(pc, h, upd_pred_taken, upd_pred_target);
    endtask

    initial begin
        logic [31:0] pool [6];
        pool[0] = 32'h10; pool[1] = 32'h40; pool[2] = 32'h44;
        pool[3] = 32'h410; pool[4] = 32'h1010; pool[5] = 32'h440;

        @(posedge clk); #1;
        model_reset();
        cycle("reset"); cycle("reset");

        // Release reset; the last sweep cycle carries a preload and init_done
        // that must both be ignored.
        rst = 1;
        for (int i = 0; i < 256; i++) begin
            if (i == 255) begin
                init_en = 1; init_done = 1; init_idx = 8'd4; init_tag = 8'h55;
                init_target = 32'hDEAD; init_ctr = 2'd1;
            end
            cycle("sweep");
        end

        // Preload idx 4, then a write coinciding with init_done.
        init_done = 0; init_en = 1; init_idx = 8'd4; init_tag = 8'd0;
        init_target = 32'h100; init_ctr = 2'd3;
        cycle("init_wait");
        init_idx = 8'd16; init_tag = 8'd1; init_target = 32'h200; init_ctr = 2'd0; init_done = 1;
        cycle("init_last");
        init_en = 0; init_done = 0;
        if_pc = 32'h10;  cycle("preload_hit");
        if_pc = 32'h440; cycle("preload_done_write");
        if_pc = 32'h1010; cycle("tag_miss");

        // Training with same-cycle lookup of the updated index.
        if_pc = 32'h10;
        for (int i = 0; i < 3; i++) begin
            upd_model(32'h10, 1'b0, 32'h0);
            cycle("train_nt");
        end
        upd_valid = 0;
        cycle("train_done");

        // Allocation on taken miss, none on not-taken miss.
        upd_model(32'h40, 1'b1, 32'h80); if_pc = 32'h40; cycle("alloc_taken");
        upd_valid = 0; cycle("alloc_lookup");
        upd_model(32'h40, 1'b0, 32'h0); cycle("alloc_ctr2");
        upd_valid = 0; cycle("alloc_ctr1");
        upd_model(32'h44, 1'b0, 32'h0); if_pc = 32'h44; cycle("nt_miss");
        upd_valid = 0; cycle("nt_miss_lookup");

        // Stat saturation: 20 deliberately mispredicted updates.
        for (int i = 0; i < 20; i++) begin
            upd_valid = 1; upd_pc = 32'h80 + 32'(i * 4); upd_taken = 1;
            upd_target = 32'h300 + 32'(i); upd_pred_taken = 0; upd_pred_target = 32'h0;
            if_pc = upd_pc;
            cycle("stat_sat");
        end
        upd_valid = 0; cycle("stat_hold");

        // Randomized traffic, including stray preload strobes.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc;
            pc = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h0003_FFFC) : pool[$urandom_range(0, 5)];
            if_pc = ($urandom_range(0, 1) == 0) ? pc : pool[$urandom_range(0, 5)];
            init_en = 1'($urandom); init_done = 1'($urandom);
            init_idx = 8'($urandom); init_tag = 8'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                upd_model(pc, 1'($urandom), ($urandom_range(0, 1) == 0) ? 32'h100 : ($urandom & 32'hFFFC));
                if ($urandom_range(0, 3) == 0) begin
                    upd_pred_taken = 1'($urandom); upd_pred_target = $urandom & 32'h3FC;
                end
            end else begin
                upd_valid = 0;
            end
            cycle("random");
        end

        // Asynchronous reset mid-run, then again mid-sweep.
        init_en = 0; init_done = 0; upd_model(32'h10, 1'b1, 32'h500);
        rst = 0; model_reset();
        cycle("reset_mid_run");
        cycle("reset_hold");
        rst = 1;
        for (int i = 0; i < 10; i++) cycle("resweep");
        rst = 0; model_reset();
        cycle("reset_mid_sweep");
        rst = 1; upd_valid = 0;
        cycle("resweep2");

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter IDX_BITS, default 8, meaning log2 of the table entry count.
REQ-002 SHALL have parameter TAG_BITS, default 8, meaning tag width per entry.
REQ-003 SHALL have parameter CTR_BITS, default 2, range 1..4, meaning saturating-counter width.
REQ-004 SHALL have parameter STAT_BITS, default 16, meaning statistics counter width.
REQ-005 SHALL have ports clk (input, 1, sole clock) and rst (input, 1); rst is asynchronous and active-low.
REQ-006 SHALL have ports init_en (input, 1, preload strobe); init_idx (input, IDX_BITS); init_tag (input, TAG_BITS); init_target (input, 32); init_ctr (input, CTR_BITS).
REQ-007 SHALL have port init_done (input, 1), a one-cycle pulse ending preload.
REQ-008 SHALL have ports if_pc (input, 32, fetch PC); pred_hit (output, 1); pred_taken (output, 1); pred_target (output, 32).
REQ-009 SHALL have ports upd_valid (input, 1, resolved branch); upd_pc (input, 32); upd_taken (input, 1, actual outcome); upd_target (input, 32, actual target).
REQ-010 SHALL have ports upd_pred_taken (input, 1) and upd_pred_target (input, 32), the prediction made at fetch.
REQ-011 SHALL have ports ready (output, 1); mispredict (output, 1); redirect_pc (output, 32); stat_branches (output, STAT_BITS); stat_miss (output, STAT_BITS).

Function
REQ-012 SHALL derive idx = pc[IDX_BITS+1:2] and tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2].
REQ-013 SHALL store per entry: valid, tag, 32-bit target, and a CTR_BITS counter.
REQ-014 SHALL implement FSM states CLEAR, INIT and RUN.
REQ-015 SHALL sweep one entry per cycle in CLEAR (valid=0, ctr=2^(CTR_BITS-1)-1), then enter INIT after the last index.
REQ-016 SHALL in INIT write the init_* fields to entry init_idx with valid=1 when init_en=1, and enter RUN on init_done.
REQ-017 SHALL, when init_en and init_done coincide, perform the write and then enter RUN.
REQ-018 SHALL ignore init_en outside INIT.
REQ-019 SHALL drive ready=1 only in RUN; ready=0 forces pred_hit=0 and pred_taken=0 and ignores upd_valid.
REQ-020 SHALL generate lookup combinationally with zero latency: pred_hit = valid and tag match; pred_taken = pred_hit and ctr MSB; pred_target = stored target when pred_hit, else if_pc+4.
REQ-021 SHALL, on upd_valid in RUN with tag hit, saturate-increment ctr if taken or saturate-decrement otherwise, and overwrite target when taken.
REQ-022 SHALL, on upd_valid with a tag miss and taken, allocate the entry (valid=1, new tag, upd_target, ctr=2^(CTR_BITS-1)); a not-taken miss SHALL leave the table unchanged.
REQ-023 SHALL determine the mispredict condition as (upd_taken != upd_pred_taken) or (upd_taken and upd_target != upd_pred_target).
REQ-024 SHALL register mispredict, pulsing for one cycle the edge after upd_valid; redirect_pc is registered as upd_target if taken, else upd_pc+4.
REQ-025 SHALL make table writes take effect on the clock edge, so a same-cycle lookup of the index being updated returns the old contents.
REQ-026 SHALL increment stat_branches on each accepted update and stat_miss on each mispredict, both saturating at all-ones.

Reset
REQ-027 SHALL, on rst=0, immediately enter CLEAR, restart the sweep at index 0, clear ready, mispredict, redirect_pc and both stat counters, and hold pred_* at 0/0/if_pc+4.
REQ-028 SHALL, on reset asserted mid-sweep or mid-INIT, abandon that operation; prior table contents are don't-care until re-cleared.

Structure
REQ-029 SHALL place the FSM state enum, the default parameter values and the counter-midpoint constant in a shared package bp_pkg.
REQ-030 SHALL implement the saturating counter as one sub-module, sat_ctr, parameterised by CTR_BITS.
REQ-031 SHALL use plain registers for the table, with no memory macro, so that the asynchronous clear is permitted.

Verification
REQ-032 SHALL cover reset: rst released -> ready=0 for exactly 256 cycles, INIT, then init_done -> ready=1 next cycle.
REQ-033 SHALL cover preload: init idx 4, tag 0, target 0x100, ctr 3 -> if_pc=0x10 gives pred_hit=1, pred_taken=1, pred_target=0x100.
REQ-034 SHALL cover training: three not-taken updates on pc 0x10 -> ctr 0, pred_taken=0, and the first update pulses mispredict with redirect_pc=0x14.
REQ-035 SHALL cover allocation: taken miss at pc 0x40 with target 0x80 -> entry allocated with ctr=2; a not-taken miss at pc 0x44 -> pred_hit stays 0.
REQ-036 SHALL cover collision: same-cycle update and lookup of index 4 -> old prediction, new prediction next cycle.
REQ-037 SHALL cover saturation: STAT_BITS=4 and 20 mispredicting updates -> stat_miss=15 and stat_branches=15.
